// File: rtl/conv_pe_acc_if.sv
// conv_pe_acc_if: beat/result bundle between the data_gen stage and the conv MAC stage.
//  master : data_gen side. It drives data_in, weight_in, data_in_vld, data_acc_s and
//           data_acc_para, and it receives psum_out, psum_vld and acc_err.
//  slave  : conv_pe_acc side. Its directions are the reverse of master.
interface conv_pe_acc_if #(
  parameter int LANES  = 16,
  parameter int TAPS   = 9,
  parameter int SLOT_W = 32,
  parameter int ACC_W  = 32
);
  logic [LANES*TAPS*SLOT_W-1:0] data_in;
  logic                         data_in_vld;
  logic                         data_acc_s;
  logic [7:0]                   data_acc_para;
  logic [LANES*TAPS*SLOT_W-1:0] weight_in;
  logic [LANES*ACC_W-1:0]       psum_out;
  logic                         psum_vld;
  logic                         acc_err;

  modport master (
    output data_in, data_in_vld, data_acc_s, data_acc_para, weight_in,
    input  psum_out, psum_vld, acc_err
  );

  modport slave (
    input  data_in, data_in_vld, data_acc_s, data_acc_para, weight_in,
    output psum_out, psum_vld, acc_err
  );
endinterface

// File: rtl/conv_pe_acc.sv
// conv_pe_acc: per-lane int8 3x3 x 4-channel MAC with accumulation over a group of beats.
//  clk_100M : compute clock
//  rst_n    : asynchronous reset, active-low
//  bus      : conv_pe_acc_if.slave
//             inputs  : activation and weight beats, valid, group start, group length
//             outputs : per-lane partial sums, result pulse, protocol-error pulse
// Pipeline: edge T registers the beat and the group flags. S1 forms the products,
// S2 adds them per lane, and S3 accumulates and publishes the result.
module conv_pe_acc #(
  parameter int LANES  = 16,
  parameter int TAPS   = 9,
  parameter int SLOT_W = 32,
  parameter int ACC_W  = 32
) (
  input logic         clk_100M,
  input logic         rst_n,
  conv_pe_acc_if.slave bus
);
  localparam int CH     = SLOT_W / 8;
  localparam int TERMS  = TAPS * CH;
  localparam int LANE_W = TAPS * SLOT_W;
  localparam int SUM_W  = 21;

  // input stage
  logic [LANES*LANE_W-1:0] act_r, wgt_r;
  logic                    vld0, first0, last0;
  logic                    open;
  logic [7:0]              cnt, para_lat;
  logic                    err_r;
  // S1
  logic signed [15:0]      prod [LANES][TERMS];
  logic                    vld1, first1, last1;
  // S2
  logic signed [SUM_W-1:0] sum_c [LANES];
  logic signed [SUM_W-1:0] sum_r [LANES];
  logic                    vld2, first2, last2;
  // S3
  logic signed [ACC_W-1:0] acc     [LANES];
  logic signed [ACC_W-1:0] acc_nxt [LANES];
  logic [LANES*ACC_W-1:0]  psum_r;
  logic                    psum_vld_r;

  function automatic logic signed [15:0] mul8(input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] ax, bx;
    ax = {{8{a[7]}}, a};
    bx = {{8{b[7]}}, b};
    return ax * bx;
  endfunction

  // Group control. A start while a group is open aborts that group. The abort needs no
  // explicit kill: the old group's closing beat never arrives, and the new first beat
  // reloads the accumulator.
  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      act_r    <= '0;
      wgt_r    <= '0;
      vld0     <= 1'b0;
      first0   <= 1'b0;
      last0    <= 1'b0;
      open     <= 1'b0;
      cnt      <= '0;
      para_lat <= '0;
      err_r    <= 1'b0;
    end else begin
      vld0   <= 1'b0;
      first0 <= 1'b0;
      last0  <= 1'b0;
      err_r  <= 1'b0;
      if (bus.data_in_vld) begin
        act_r <= bus.data_in;
        wgt_r <= bus.weight_in;
        if (bus.data_acc_s) begin
          err_r    <= open;
          vld0     <= 1'b1;
          first0   <= 1'b1;
          cnt      <= 8'd1;
          para_lat <= (bus.data_acc_para == 8'd0) ? 8'd1 : bus.data_acc_para;
          if (bus.data_acc_para <= 8'd1) begin
            last0 <= 1'b1;
            open  <= 1'b0;
          end else begin
            open  <= 1'b1;
          end
        end else if (open) begin
          vld0 <= 1'b1;
          if (({1'b0, cnt} + 9'd1) == {1'b0, para_lat}) begin
            last0 <= 1'b1;
            open  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end else begin
          err_r <= 1'b1;
        end
      end
    end
  end

  // S1: products
  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      vld1   <= 1'b0;
      first1 <= 1'b0;
      last1  <= 1'b0;
      for (int l = 0; l < LANES; l++)
        for (int k = 0; k < TERMS; k++)
          prod[l][k] <= '0;
    end else begin
      vld1   <= vld0;
      first1 <= first0;
      last1  <= last0;
      for (int l = 0; l < LANES; l++)
        for (int k = 0; k < TERMS; k++)
          prod[l][k] <= mul8(act_r[l*LANE_W + k*8 +: 8], wgt_r[l*LANE_W + k*8 +: 8]);
    end
  end

  // S2: per-lane sum of products
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      sum_c[l] = '0;
      for (int k = 0; k < TERMS; k++)
        sum_c[l] = sum_c[l] + {{(SUM_W-16){prod[l][k][15]}}, prod[l][k]};
    end
  end

  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      vld2   <= 1'b0;
      first2 <= 1'b0;
      last2  <= 1'b0;
      for (int l = 0; l < LANES; l++) sum_r[l] <= '0;
    end else begin
      vld2   <= vld1;
      first2 <= first1;
      last2  <= last1;
      for (int l = 0; l < LANES; l++) sum_r[l] <= sum_c[l];
    end
  end

  // S3: accumulate
  always_comb begin
    for (int l = 0; l < LANES; l++)
      acc_nxt[l] = {{(ACC_W-SUM_W){sum_r[l][SUM_W-1]}}, sum_r[l]} + (first2 ? '0 : acc[l]);
  end

  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      psum_r     <= '0;
      psum_vld_r <= 1'b0;
      for (int l = 0; l < LANES; l++) acc[l] <= '0;
    end else begin
      psum_vld_r <= vld2 & last2;
      if (vld2) begin
        for (int l = 0; l < LANES; l++) begin
          acc[l] <= acc_nxt[l];
          if (last2) psum_r[l*ACC_W +: ACC_W] <= acc_nxt[l];
        end
      end
    end
  end

  assign bus.psum_out = psum_r;
  assign bus.psum_vld = psum_vld_r;
  assign bus.acc_err  = err_r;
endmodule

// File: tb/tb_conv_pe_acc.sv
module tb_conv_pe_acc;
  localparam int LANES = 16;
  localparam int LW    = 288;
  localparam int W     = LANES * LW;

  logic clk_100M = 1'b0;
  logic rst_n    = 1'b0;
  always #5 clk_100M = ~clk_100M;

  conv_pe_acc_if bus ();
  conv_pe_acc dut (.clk_100M(clk_100M), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;
  int vld_seen = 0;
  int err_seen = 0;
  logic [7:0] av [LANES];
  logic [7:0] wv [LANES];

  always @(posedge clk_100M) begin
    #1;
    if (bus.psum_vld === 1'b1) vld_seen++;
    if (bus.acc_err === 1'b1) err_seen++;
  end

  function automatic logic [W-1:0] pack(input logic [7:0] v [LANES]);
    logic [W-1:0] r;
    r = '0;
    for (int l = 0; l < LANES; l++)
      for (int s = 0; s < 36; s++)
        r[l*LW + s*8 +: 8] = v[l];
    return r;
  endfunction

  task automatic put_beat(input logic s, input logic [7:0] para);
    bus.data_in       = pack(av);
    bus.weight_in     = pack(wv);
    bus.data_in_vld   = 1'b1;
    bus.data_acc_s    = s;
    bus.data_acc_para = para;
    @(negedge clk_100M);
  endtask

  task automatic idle(input int n);
    bus.data_in_vld = 1'b0;
    bus.data_acc_s  = 1'b0;
    repeat (n) @(negedge clk_100M);
  endtask

  task automatic set_all(input logic [7:0] a, input logic [7:0] w);
    for (int l = 0; l < LANES; l++) begin
      av[l] = a;
      wv[l] = w;
    end
  endtask

  task automatic test_reset;
    logic [31:0] got;
    repeat (2) @(negedge clk_100M);
    checks++;
    if (bus.psum_out !== '0) begin
      errors++; $display("FAIL reset_psum: got %h expected 0", bus.psum_out[31:0]);
    end
    checks++;
    if (bus.psum_vld !== 1'b0) begin
      errors++; $display("FAIL reset_vld: got %b expected 0", bus.psum_vld);
    end
    checks++;
    if (bus.acc_err !== 1'b0) begin
      errors++; $display("FAIL reset_err: got %b expected 0", bus.acc_err);
    end
    rst_n = 1'b1;
    @(negedge clk_100M);
    got = 32'(vld_seen);
    checks++;
    if (got !== 32'd0) begin
      errors++; $display("FAIL reset_no_vld: got %0d expected 0", got);
    end
  endtask

  task automatic test_single;
    logic signed [31:0] got;
    int e0;
    e0 = err_seen;
    set_all(8'd1, 8'd1);
    put_beat(1'b1, 8'd1);
    bus.data_in_vld = 1'b0;
    bus.data_acc_s  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk_100M);
      checks++;
      if (bus.psum_vld !== (k == 3)) begin
        errors++; $display("FAIL single_latency_%0d: got %b expected %b", k, bus.psum_vld, (k == 3));
      end
    end
    for (int l = 0; l < LANES; l++) begin
      got = $signed(bus.psum_out[l*32 +: 32]);
      checks++;
      if (got !== 32'sd36) begin
        errors++; $display("FAIL single_lane%0d: got %0d expected 36", l, got);
      end
    end
    checks++;
    if (err_seen !== e0) begin
      errors++; $display("FAIL single_err: got %0d expected %0d", err_seen, e0);
    end
  endtask

  task automatic test_back_to_back;
    logic signed [31:0] got;
    int v0;
    v0 = vld_seen;
    for (int l = 0; l < LANES; l++) begin
      av[l] = 8'd1;
      wv[l] = 8'(l);
    end
    put_beat(1'b1, 8'd3);
    put_beat(1'b0, 8'd0);
    put_beat(1'b0, 8'd0);
    idle(6);
    checks++;
    if (vld_seen - v0 !== 1) begin
      errors++; $display("FAIL b2b_vld_count: got %0d expected 1", vld_seen - v0);
    end
    for (int l = 0; l < LANES; l++) begin
      got = $signed(bus.psum_out[l*32 +: 32]);
      checks++;
      if (got !== 32'(108 * l)) begin
        errors++; $display("FAIL b2b_lane%0d: got %0d expected %0d", l, got, 108 * l);
      end
    end
  endtask

  task automatic test_gaps;
    logic signed [31:0] got;
    int v0;
    v0 = vld_seen;
    set_all(8'h80, 8'h80);
    put_beat(1'b1, 8'd2);
    idle(5);
    checks++;
    if (vld_seen !== v0) begin
      errors++; $display("FAIL gaps_early_vld: got %0d expected %0d", vld_seen, v0);
    end
    put_beat(1'b0, 8'd0);
    idle(6);
    checks++;
    if (vld_seen - v0 !== 1) begin
      errors++; $display("FAIL gaps_vld_count: got %0d expected 1", vld_seen - v0);
    end
    for (int l = 0; l < LANES; l++) begin
      got = $signed(bus.psum_out[l*32 +: 32]);
      checks++;
      if (got !== 32'sd1179648) begin
        errors++; $display("FAIL gaps_lane%0d: got %0d expected 1179648", l, got);
      end
    end
  endtask

  task automatic test_abort;
    logic signed [31:0] got;
    int v0, e0;
    v0 = vld_seen;
    e0 = err_seen;
    set_all(8'd1, 8'd1);
    put_beat(1'b1, 8'd4);
    put_beat(1'b0, 8'd0);
    put_beat(1'b1, 8'd1);
    idle(6);
    checks++;
    if (err_seen - e0 !== 1) begin
      errors++; $display("FAIL abort_err: got %0d expected 1", err_seen - e0);
    end
    checks++;
    if (vld_seen - v0 !== 1) begin
      errors++; $display("FAIL abort_vld_count: got %0d expected 1", vld_seen - v0);
    end
    for (int l = 0; l < LANES; l++) begin
      got = $signed(bus.psum_out[l*32 +: 32]);
      checks++;
      if (got !== 32'sd36) begin
        errors++; $display("FAIL abort_lane%0d: got %0d expected 36", l, got);
      end
    end
    v0 = vld_seen;
    e0 = err_seen;
    set_all(8'd5, 8'd5);
    put_beat(1'b0, 8'd0);
    idle(6);
    checks++;
    if (err_seen - e0 !== 1) begin
      errors++; $display("FAIL stray_err: got %0d expected 1", err_seen - e0);
    end
    checks++;
    if (vld_seen !== v0) begin
      errors++; $display("FAIL stray_vld: got %0d expected %0d", vld_seen, v0);
    end
    got = $signed(bus.psum_out[31:0]);
    checks++;
    if (got !== 32'sd36) begin
      errors++; $display("FAIL stray_hold: got %0d expected 36", got);
    end
  endtask

  task automatic test_long_group;
    logic signed [31:0] got;
    logic signed [31:0] exp0;
    int v0;
    v0 = vld_seen;
    exp0 = 32'(-16256 * 36 * 255);
    set_all(8'd0, 8'd0);
    av[0] = 8'd127;
    wv[0] = 8'h80;
    for (int i = 0; i < 255; i++) put_beat(i == 0, 8'd255);
    idle(6);
    checks++;
    if (vld_seen - v0 !== 1) begin
      errors++; $display("FAIL long_vld_count: got %0d expected 1", vld_seen - v0);
    end
    got = $signed(bus.psum_out[31:0]);
    checks++;
    if (got !== exp0) begin
      errors++; $display("FAIL long_lane0: got %0d expected %0d", got, exp0);
    end
    for (int l = 1; l < LANES; l++) begin
      got = $signed(bus.psum_out[l*32 +: 32]);
      checks++;
      if (got !== 32'sd0) begin
        errors++; $display("FAIL long_lane%0d: got %0d expected 0", l, got);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic signed [31:0] got;
    int v0;
    set_all(8'd1, 8'd1);
    put_beat(1'b1, 8'd3);
    put_beat(1'b0, 8'd0);
    bus.data_in_vld = 1'b0;
    bus.data_acc_s  = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.psum_out !== '0) begin
      errors++; $display("FAIL midrst_psum: got %h expected 0", bus.psum_out[31:0]);
    end
    checks++;
    if (bus.psum_vld !== 1'b0 || bus.acc_err !== 1'b0) begin
      errors++; $display("FAIL midrst_flags: got vld %b err %b expected 0 0", bus.psum_vld, bus.acc_err);
    end
    repeat (2) @(negedge clk_100M);
    rst_n = 1'b1;
    v0 = vld_seen;
    idle(6);
    checks++;
    if (vld_seen !== v0) begin
      errors++; $display("FAIL midrst_no_vld: got %0d expected %0d", vld_seen, v0);
    end
    put_beat(1'b1, 8'd1);
    idle(6);
    checks++;
    if (vld_seen - v0 !== 1) begin
      errors++; $display("FAIL midrst_vld_count: got %0d expected 1", vld_seen - v0);
    end
    for (int l = 0; l < LANES; l++) begin
      got = $signed(bus.psum_out[l*32 +: 32]);
      checks++;
      if (got !== 32'sd36) begin
        errors++; $display("FAIL midrst_lane%0d: got %0d expected 36", l, got);
      end
    end
  endtask

  initial begin
    bus.data_in       = '0;
    bus.weight_in     = '0;
    bus.data_in_vld   = 1'b0;
    bus.data_acc_s    = 1'b0;
    bus.data_acc_para = 8'd0;
    set_all(8'd0, 8'd0);
    test_reset();
    test_single();
    test_back_to_back();
    test_gaps();
    test_abort();
    test_long_group();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
